// File: rtl/pal_cfg_loader.sv
// rtl/pal_cfg_loader.sv - framed byte loader that serialises a PAL config chain and commits on checksum match
module pal_cfg_loader #(
    parameter int          CFG_BITS  = 240,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          NUM_BYTES = (CFG_BITS + 7) / 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_data,
    output logic       cfg_shift,
    output logic       cfg_commit,
    output logic       cfg_valid,
    output logic       busy,
    output logic       err
);

    localparam int PAD = NUM_BYTES * 8 - CFG_BITS;
    localparam int BCW = $clog2(NUM_BYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      sreg;
    logic [7:0]      csum;
    logic [3:0]      bit_cnt;
    logic [BCW-1:0]  byte_cnt;
    logic            accept;
    logic            shifting;
    logic            is_pad;
    logic            last_bit;

    assign accept   = in_valid & in_ready;
    assign shifting = (state == S_PAYLOAD) && (bit_cnt != 4'd0);
    // Leading bits of the first byte fall off the front of the chain and must not be strobed.
    assign is_pad   = (byte_cnt == BCW'(1)) && (bit_cnt > 4'(8 - PAD));
    assign last_bit = (state == S_PAYLOAD) && (bit_cnt == 4'd1) && (byte_cnt == BCW'(NUM_BYTES));

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_IDLE:    in_ready = 1'b1;
            S_PAYLOAD: in_ready = (bit_cnt == 4'd0);
            S_CHECK:   in_ready = 1'b1;
            default:   in_ready = 1'b0;
        endcase
    end

    assign cfg_shift  = shifting && !is_pad;
    assign cfg_data   = shifting ? sreg[7] : 1'b0;
    assign cfg_commit = (state == S_COMMIT);
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept && (in_data == SYNC_BYTE))
                    state_nx = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (last_bit)
                    state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (accept)
                    state_nx = (in_data == csum) ? S_COMMIT : S_IDLE;
            end
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= 8'd0;
            csum      <= 8'd0;
            bit_cnt   <= 4'd0;
            byte_cnt  <= '0;
            err       <= 1'b0;
            cfg_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && (in_data == SYNC_BYTE)) begin
                        err       <= 1'b0;
                        cfg_valid <= 1'b0;
                        csum      <= 8'd0;
                        byte_cnt  <= '0;
                        bit_cnt   <= 4'd0;
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        sreg     <= in_data;
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + BCW'(1);
                        bit_cnt  <= 4'd8;
                    end else if (bit_cnt != 4'd0) begin
                        sreg    <= {sreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (accept && (in_data != csum))
                        err <= 1'b1;
                end
                S_COMMIT: cfg_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb/tb_pal_cfg_loader.sv - scoreboard bench for pal_cfg_loader (240-bit and 236-bit padded instances)
module tb_pal_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, cfg_data, cfg_shift, cfg_commit, cfg_valid, busy, err;
    logic       p_ready, p_data, p_shift, p_commit, p_valid, p_busy, p_err;

    int total = 0;
    int bad   = 0;
    int shift_cnt = 0, pshift_cnt = 0, commit_cnt = 0, pcommit_cnt = 0;
    bit exp_q[$];
    bit pexp_q[$];

    always #5 clk = ~clk;

    pal_cfg_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cfg_data(cfg_data), .cfg_shift(cfg_shift),
        .cfg_commit(cfg_commit), .cfg_valid(cfg_valid), .busy(busy), .err(err)
    );

    pal_cfg_loader #(.CFG_BITS(236)) dut_pad (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(p_ready), .cfg_data(p_data), .cfg_shift(p_shift),
        .cfg_commit(p_commit), .cfg_valid(p_valid), .busy(p_busy), .err(p_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_shift) begin
                shift_cnt++;
                check("main_q_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("main_bit", cfg_data, exp_q.pop_front());
            end else begin
                check("main_data_idle_zero", cfg_data, 0);
            end
            check("main_shift_commit_excl", cfg_shift & cfg_commit, 0);
            if (cfg_commit) commit_cnt++;
            if (p_shift) begin
                pshift_cnt++;
                check("pad_q_nonempty", pexp_q.size() > 0, 1);
                if (pexp_q.size() > 0) check("pad_bit", p_data, pexp_q.pop_front());
            end
            check("pad_shift_commit_excl", p_shift & p_commit, 0);
            if (p_commit) pcommit_cnt++;
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit first);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(b[i]);
            if (!(first && (7 - i) < 4)) pexp_q.push_back(b[i]);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the byte is accepted.
    task automatic send(input logic [7:0] b, output int waited);
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("ready_timeout", waited < 40, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_payload(input int idx, input logic [7:0] first, input bit gaps);
        logic [7:0] b;
        int w;
        b = (idx == 0) ? first : 8'(idx + 1);
        push_byte(b, idx == 0);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        send(b, w);
        if (!gaps && idx > 0) check("payload_spacing", w, 8);
    endtask

    task automatic send_frame(input logic [7:0] first, input logic [7:0] cs, input bit gaps);
        int w;
        shift_cnt = 0; pshift_cnt = 0; commit_cnt = 0; pcommit_cnt = 0;
        send(8'hA5, w);
        check("busy_after_sync", busy, 1);
        for (int i = 0; i < 30; i++) send_payload(i, first, gaps);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        send(cs, w);
        if (!gaps) check("csum_spacing", w, 8);
        repeat (3) @(negedge clk);
        check("shift_count", shift_cnt, 240);
        check("pad_shift_count", pshift_cnt, 236);
        check("queue_drained", exp_q.size(), 0);
        check("pad_queue_drained", pexp_q.size(), 0);
        check("busy_after_frame", busy, 0);
    endtask

    task automatic expect_good();
        check("commit_once", commit_cnt, 1);
        check("pad_commit_once", pcommit_cnt, 1);
        check("cfg_valid_set", cfg_valid, 1);
        check("pad_cfg_valid_set", p_valid, 1);
        check("err_clear", err, 0);
    endtask

    initial begin
        int w;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_cfg_data", cfg_data, 0);
        check("rst_cfg_shift", cfg_shift, 0);
        check("rst_cfg_commit", cfg_commit, 0);
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        send(8'h00, w);
        check("junk_busy", busy, 0);
        check("junk_in_ready", in_ready, 1);
        check("junk_err", err, 0);
        check("junk_valid", cfg_valid, 0);

        send_frame(8'h01, 8'h1F, 1'b0);
        expect_good();

        send_frame(8'h01, 8'h00, 1'b0);
        check("bad_no_commit", commit_cnt, 0);
        check("bad_pad_no_commit", pcommit_cnt, 0);
        check("bad_err", err, 1);
        check("bad_pad_err", p_err, 1);
        check("bad_valid", cfg_valid, 0);
        send(8'hA5, w);
        check("resync_err_clear", err, 0);
        check("resync_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); pexp_q.delete();
        @(negedge clk);

        send_frame(8'h01, 8'h1F, 1'b1);
        expect_good();

        send_frame(8'hFF, 8'hE1, 1'b0);
        expect_good();

        commit_cnt = 0;
        send(8'hA5, w);
        for (int i = 0; i < 10; i++) send_payload(i, 8'h01, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", cfg_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_shift", cfg_shift, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete(); pexp_q.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_no_commit", commit_cnt, 0);
        check("midrst_valid_hold", cfg_valid, 0);

        send_frame(8'h01, 8'h1F, 1'b0);
        expect_good();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
Byte-wide configuration front end that sits directly upstream of the PAL fabric's serial configuration input. It accepts a framed bitstream from a host byte at a time over a valid/ready handshake: a sync byte, then the payload bytes, then an XOR checksum. It serialises the payload MSB-first onto the PAL config bit line with a per-bit shift strobe. It issues a single commit pulse only when the frame checksum matches, so a corrupted load never gets applied.

Parameters:
CFG_BITS, 240, configuration chain length in bits (2*N*P + P*M for N=8, P=12, M=4).
SYNC_BYTE, 8'hA5, frame start marker.
NUM_BYTES, (CFG_BITS+7)/8, payload byte count (derived; 30 at default).

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  8  host byte
in_valid  in  1  host byte valid
in_ready  out  1  loader can accept a byte this cycle
cfg_data  out  1  serial config bit to PAL
cfg_shift  out  1  qualifier, PAL shifts cfg_data on this cycle's clk edge
cfg_commit  out  1  one-cycle pulse, PAL applies shifted configuration
cfg_valid  out  1  level, a verified configuration has been committed
busy  out  1  frame in progress (sync seen, commit/error not yet reached)
err  out  1  sticky checksum error flag

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, cfg_data=0, cfg_shift=0, cfg_commit=0, cfg_valid=0, busy=0, err=0, byte counter=0, bit counter=0, checksum=0.
- A byte is accepted on a rising edge with in_valid & in_ready. in_ready=1 only in IDLE, in PAYLOAD with bit counter=0, and in CHECK.
- IDLE: accepted byte == SYNC_BYTE -> PAYLOAD; clear err, cfg_valid, checksum, byte counter; busy=1. Any other byte is consumed and ignored, with no flag change.
- PAYLOAD: an accepted byte is loaded into the shift register and XORed into the checksum. On the following 8 cycles cfg_shift=1 and cfg_data = bit 7,6,...,0 in turn, and in_ready=0. in_ready returns the cycle after the 8th bit. Throughput is 1 byte per 9 cycles minimum.
- Padding: PAD = NUM_BYTES*8 - CFG_BITS. The first PAD bits of the first payload byte are still clocked out internally, but cfg_shift=0 for them. Exactly CFG_BITS strobes are issued per frame.
- After the last bit of byte NUM_BYTES-1 -> CHECK.
- CHECK: next accepted byte is compared with the running XOR.
  - Match -> COMMIT for one cycle: cfg_commit=1, then cfg_valid=1, busy=0, state IDLE.
  - Mismatch -> err=1, cfg_valid stays 0, busy=0, state IDLE, no commit.
- SYNC_BYTE inside PAYLOAD or CHECK has no special meaning: it is treated as data or checksum. There is no mid-frame resync.
- in_valid deasserting mid-frame stalls the frame indefinitely. Outputs hold, cfg_shift=0 while idle-waiting.
- cfg_shift and cfg_commit are never high in the same cycle. cfg_data is 0 whenever cfg_shift=0, except during pad bits.
- Reset mid-frame returns everything to reset values immediately. Any partial chain contents in the PAL are not committed, and cfg_valid stays 0.
- cfg_valid and err are mutually exclusive. Both are cleared only by the next accepted SYNC_BYTE or by reset.

Test Plan:
- Reset check: hold rst_n=0 with in_valid=1 -> all outputs at reset values; release; send 8'h00 -> consumed, no state change, busy=0.
- Good frame: 8'hA5, 30 bytes 8'h01..8'h1E, checksum 8'h1F -> exactly 240 cfg_shift pulses. Bit stream equals the bytes MSB-first. cfg_commit pulses once, cfg_valid=1, err=0.
- Bad checksum: same frame, checksum 8'h00 -> 240 shifts, no cfg_commit, err=1, cfg_valid=0. New 8'hA5 -> err clears.
- Handshake timing: back-to-back valid -> in_ready low exactly 8 cycles after each payload accept, 9-cycle byte spacing. Random in_valid gaps -> identical bit stream.
- Padding (CFG_BITS=236): first byte 8'hFF -> only 4 strobes for that byte, total 236 strobes.
- Reset mid-frame: assert rst_n=0 after byte 10 -> no commit, cfg_valid=0. Subsequent full good frame commits normally.
